// File: rtl/bpfvm_pkg.sv
//------------------------------------------------------------------------------
// Module   : bpfvm_pkg
// Purpose  : Shared definitions for the BPF CPU packet-buffer scheduler:
//            per-buffer state encoding and the number of ping-pong buffers.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bpfvm_pkg;

  // Two buffers alternate between the snooper, the CPU and the forwarder.
  localparam int NUM_BUFS = 2;

  typedef logic [2:0] buf_state_t;

  localparam buf_state_t BUF_EMPTY    = 3'd0;
  localparam buf_state_t BUF_FILLING  = 3'd1;
  localparam buf_state_t BUF_READY    = 3'd2;
  localparam buf_state_t BUF_FILTER   = 3'd3;
  localparam buf_state_t BUF_ACCEPTED = 3'd4;

endpackage

`default_nettype wire

// File: rtl/bpfvm_sched_buf.sv
//------------------------------------------------------------------------------
// Module   : bpfvm_sched_buf
// Purpose  : State and length register for one packet buffer. Moves through
//            EMPTY -> FILLING -> READY -> FILTER -> ACCEPTED -> EMPTY under the
//            control of one-cycle strobes from the scheduler top level.
// Ports    : clk, rst (async, active-low)
//            alloc    - EMPTY -> FILLING
//            done     - FILLING -> READY (or EMPTY when done_len is zero)
//            done_len - packet length captured with done
//            start    - READY -> FILTER
//            accept   - FILTER -> ACCEPTED (takes priority over reject)
//            reject   - FILTER -> EMPTY
//            drain    - ACCEPTED -> EMPTY
//            state    - current buffer state
//            len      - last captured packet length
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bpfvm_sched_buf
  import bpfvm_pkg::*;
#(
  parameter int LEN_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc,
  input  logic                 done,
  input  logic [LEN_WIDTH-1:0] done_len,
  input  logic                 start,
  input  logic                 accept,
  input  logic                 reject,
  input  logic                 drain,
  output buf_state_t           state,
  output logic [LEN_WIDTH-1:0] len
);

  buf_state_t           r_state;
  buf_state_t           w_state_nxt;
  logic [LEN_WIDTH-1:0] r_len;

  // Each strobe only has an effect in the state it belongs to, so the top
  // level may raise strobes without re-checking this buffer's state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BUF_EMPTY:    if (alloc) w_state_nxt = BUF_FILLING;
      BUF_FILLING:  if (done) w_state_nxt = (done_len == '0) ? BUF_EMPTY : BUF_READY;
      BUF_READY:    if (start) w_state_nxt = BUF_FILTER;
      BUF_FILTER: begin
        if (accept)      w_state_nxt = BUF_ACCEPTED;
        else if (reject) w_state_nxt = BUF_EMPTY;
      end
      BUF_ACCEPTED: if (drain) w_state_nxt = BUF_EMPTY;
      default:      w_state_nxt = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= BUF_EMPTY;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == BUF_FILLING) && done) r_len <= done_len;
    end
  end

  assign state = r_state;
  assign len   = r_len;

endmodule

`default_nettype wire

// File: rtl/bpfvm_sched.sv
//------------------------------------------------------------------------------
// Module   : bpfvm_sched
// Purpose  : Ping-pong packet buffer scheduler for one BPF CPU core. Hands each
//            of two buffers in turn to the snooper (fill), the CPU (filter)
//            and the forwarder (drain); holds the CPU in reset between packets.
// Ports    : clk, rst (async, active-low)
//            sn_grant/sn_buf, sn_done/sn_len        - snooper side
//            cpu_rst/cpu_buf/packet_len, cpu_acc/rej - CPU side
//            fwd_valid/fwd_buf/fwd_len, fwd_done     - forwarder side
//            acc_cnt/rej_cnt                         - wrapping statistics
//            wdog_trip                               - CPU timeout pulse
// Config   : BPFVM_SCHED_WATCHDOG_EN - enables the CPU verdict watchdog
//            (WDOG_CYCLES); when undefined wdog_trip is tied low.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bpfvm_sched
  import bpfvm_pkg::*;
#(
  parameter int LEN_WIDTH   = 32,
  parameter int WDOG_CYCLES = 4096,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 sn_grant,
  output logic                 sn_buf,
  input  logic                 sn_done,
  input  logic [LEN_WIDTH-1:0] sn_len,
  output logic                 cpu_rst,
  output logic                 cpu_buf,
  output logic [LEN_WIDTH-1:0] packet_len,
  input  logic                 cpu_acc,
  input  logic                 cpu_rej,
  output logic                 fwd_valid,
  output logic                 fwd_buf,
  output logic [LEN_WIDTH-1:0] fwd_len,
  input  logic                 fwd_done,
  output logic [CNT_WIDTH-1:0] acc_cnt,
  output logic [CNT_WIDTH-1:0] rej_cnt,
  output logic                 wdog_trip
);

  buf_state_t           w_state [NUM_BUFS];
  logic [LEN_WIDTH-1:0] w_len   [NUM_BUFS];

  logic [NUM_BUFS-1:0] w_is_empty;
  logic [NUM_BUFS-1:0] w_is_fill;
  logic [NUM_BUFS-1:0] w_is_ready;
  logic [NUM_BUFS-1:0] w_is_acc;

  logic r_old;        // age bit: which READY buffer became READY first
  logic w_alloc_en, w_alloc_idx;
  logic w_fill_idx, w_done_en, w_zero_len;
  logic w_start_en, w_start_idx;
  logic w_filtering, w_acc, w_rej, w_tmo;
  logic w_acc_idx, w_drain;

  //--------------------------------------------------------------------------
  // Per-buffer state registers
  //--------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_BUFS; gi++) begin : g_buf
    localparam logic IDX = 1'(gi);

    bpfvm_sched_buf #(.LEN_WIDTH(LEN_WIDTH)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .alloc    (w_alloc_en && (w_alloc_idx == IDX)),
      .done     (w_done_en  && (w_fill_idx  == IDX)),
      .done_len (sn_len),
      .start    (w_start_en && (w_start_idx == IDX)),
      .accept   (w_acc && (cpu_buf == IDX)),
      .reject   ((w_rej || w_tmo) && (cpu_buf == IDX)),
      .drain    (w_drain && (fwd_buf == IDX)),
      .state    (w_state[gi]),
      .len      (w_len[gi])
    );

    assign w_is_empty[gi] = (w_state[gi] == BUF_EMPTY);
    assign w_is_fill[gi]  = (w_state[gi] == BUF_FILLING);
    assign w_is_ready[gi] = (w_state[gi] == BUF_READY);
    assign w_is_acc[gi]   = (w_state[gi] == BUF_ACCEPTED);
  end

  //--------------------------------------------------------------------------
  // Snooper arbitration. Decisions use the current buffer states only, so a
  // buffer freed this cycle becomes allocatable from the next edge.
  //--------------------------------------------------------------------------
  assign sn_grant    = |w_is_fill;
  assign w_fill_idx  = w_is_fill[1];
  assign w_alloc_en  = !sn_grant && (|w_is_empty);
  assign w_alloc_idx = w_is_empty[0] ? 1'b0 : 1'b1;
  assign w_done_en   = sn_done && sn_grant;
  assign w_zero_len  = w_done_en && (sn_len == '0);

  //--------------------------------------------------------------------------
  // CPU arbitration. cpu_rst is only high while no buffer is in FILTER, so a
  // release can happen at most every other edge.
  //--------------------------------------------------------------------------
  assign w_start_en  = cpu_rst && (|w_is_ready);
  assign w_start_idx = (&w_is_ready) ? r_old : w_is_ready[1];
  assign w_filtering = !cpu_rst && (w_state[cpu_buf] == BUF_FILTER);
  assign w_acc       = w_filtering && cpu_acc;
  assign w_rej       = w_filtering && !cpu_acc && cpu_rej;

  //--------------------------------------------------------------------------
  // Forwarder. Once busy it only listens to fwd_done; any other ACCEPTED
  // buffer is picked up on a later edge.
  //--------------------------------------------------------------------------
  assign w_drain   = fwd_done && fwd_valid;
  assign w_acc_idx = w_is_acc[0] ? 1'b0 : 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sn_buf     <= 1'b0;
      r_old      <= 1'b0;
      cpu_rst    <= 1'b1;
      cpu_buf    <= 1'b0;
      packet_len <= '0;
      fwd_valid  <= 1'b0;
      fwd_buf    <= 1'b0;
      fwd_len    <= '0;
      acc_cnt    <= '0;
      rej_cnt    <= '0;
    end else begin
      if (w_alloc_en) sn_buf <= w_alloc_idx;

      // A buffer turning READY is the oldest unless the other is already
      // waiting in READY.
      if (w_done_en && (sn_len != '0) && !w_is_ready[~w_fill_idx])
        r_old <= w_fill_idx;

      if (w_start_en) begin
        cpu_rst    <= 1'b0;
        cpu_buf    <= w_start_idx;
        packet_len <= w_len[w_start_idx];
      end else if (w_acc || w_rej || w_tmo) begin
        cpu_rst <= 1'b1;
      end

      if (w_drain) begin
        fwd_valid <= 1'b0;
      end else if (!fwd_valid && (|w_is_acc)) begin
        fwd_valid <= 1'b1;
        fwd_buf   <= w_acc_idx;
        fwd_len   <= w_len[w_acc_idx];
      end

      acc_cnt <= acc_cnt + CNT_WIDTH'(w_acc);
      rej_cnt <= rej_cnt + CNT_WIDTH'(w_rej || w_tmo) + CNT_WIDTH'(w_zero_len);
    end
  end

  //--------------------------------------------------------------------------
  // CPU verdict watchdog
  //--------------------------------------------------------------------------
`ifdef BPFVM_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] r_wdog;

  // Expiry fires during the WDOG_CYCLES-th cycle in FILTER; a verdict in
  // that same cycle takes precedence.
  assign w_tmo = w_filtering && !cpu_acc && !cpu_rej &&
                 (r_wdog == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (w_start_en) begin
      r_wdog <= '0;
    end else if (w_filtering) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  // No timeout without the watchdog; the term keeps WDOG_CYCLES referenced.
  assign w_tmo = 1'b0 & (WDOG_CYCLES != 0);
`endif

  assign wdog_trip = w_tmo;

endmodule

`default_nettype wire

// File: tb/tb_bpfvm_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_bpfvm_sched
// Purpose  : Self-checking bench for bpfvm_sched. Table of per-cycle input
//            and expected-output records, a forwarder scoreboard fed from
//            the accept stimulus, plus hand sequences for reset and timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bpfvm_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sn_grant, sn_buf, sn_done;
  logic [31:0] sn_len;
  logic        cpu_rst, cpu_buf, cpu_acc, cpu_rej;
  logic [31:0] packet_len;
  logic        fwd_valid, fwd_buf, fwd_done;
  logic [31:0] fwd_len, acc_cnt, rej_cnt;
  logic        wdog_trip;

  bpfvm_sched #(.LEN_WIDTH(32), .WDOG_CYCLES(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .sn_grant(sn_grant), .sn_buf(sn_buf), .sn_done(sn_done), .sn_len(sn_len),
    .cpu_rst(cpu_rst), .cpu_buf(cpu_buf), .packet_len(packet_len),
    .cpu_acc(cpu_acc), .cpu_rej(cpu_rej),
    .fwd_valid(fwd_valid), .fwd_buf(fwd_buf), .fwd_len(fwd_len), .fwd_done(fwd_done),
    .acc_cnt(acc_cnt), .rej_cnt(rej_cnt), .wdog_trip(wdog_trip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sd; logic [31:0] sl; logic acc; logic rej; logic fd;
    logic g; logic gb; logic cr; logic cb; logic [31:0] pl; logic fv;
    logic [31:0] ac; logic [31:0] rc;
  } vec_t;

  typedef struct { logic b; logic [31:0] l; } fwd_t;

  int   n_pass  = 0;
  int   n_total = 0;
  fwd_t sb[$];
  vec_t last;
  logic prev_fv;
  vec_t tbl[$];

  function automatic vec_t mk(logic sd, logic [31:0] sl, logic acc, logic rej, logic fd,
                              logic g, logic gb, logic cr, logic cb, logic [31:0] pl,
                              logic fv, logic [31:0] ac, logic [31:0] rc);
    vec_t v;
    v.sd = sd; v.sl = sl; v.acc = acc; v.rej = rej; v.fd = fd;
    v.g = g; v.gb = gb; v.cr = cr; v.cb = cb; v.pl = pl; v.fv = fv; v.ac = ac; v.rc = rc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic idle_inputs();
    sn_done = 0; sn_len = 0; cpu_acc = 0; cpu_rej = 0; fwd_done = 0;
  endtask

  // Drive one cycle of stimulus, then compare every output after the edge.
  task automatic apply(vec_t v, string tag);
    fwd_t e;
    sn_done = v.sd; sn_len = v.sl; cpu_acc = v.acc; cpu_rej = v.rej; fwd_done = v.fd;
    // An accept while the CPU is expected to be filtering must later reach the forwarder.
    if (v.acc && !last.cr) begin
      e.b = last.cb; e.l = last.pl;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    idle_inputs();
    chk({tag, ".sn_grant"},   32'(sn_grant),  32'(v.g));
    if (v.g) chk({tag, ".sn_buf"}, 32'(sn_buf), 32'(v.gb));
    chk({tag, ".cpu_rst"},    32'(cpu_rst),   32'(v.cr));
    chk({tag, ".cpu_buf"},    32'(cpu_buf),   32'(v.cb));
    chk({tag, ".packet_len"}, packet_len,     v.pl);
    chk({tag, ".fwd_valid"},  32'(fwd_valid), 32'(v.fv));
    chk({tag, ".acc_cnt"},    acc_cnt,        v.ac);
    chk({tag, ".rej_cnt"},    rej_cnt,        v.rc);
    chk({tag, ".wdog_trip"},  32'(wdog_trip), 32'd0);
    if (fwd_valid && !prev_fv) begin
      if (sb.size() == 0) begin
        chk({tag, ".fwd_unexpected"}, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, ".fwd_buf"}, 32'(fwd_buf), 32'(e.b));
        chk({tag, ".fwd_len"}, fwd_len,      e.l);
      end
    end
    prev_fv = fwd_valid;
    last    = v;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, ".sn_grant"},   32'(sn_grant),  0);
    chk({tag, ".sn_buf"},     32'(sn_buf),    0);
    chk({tag, ".cpu_rst"},    32'(cpu_rst),   1);
    chk({tag, ".cpu_buf"},    32'(cpu_buf),   0);
    chk({tag, ".packet_len"}, packet_len,     0);
    chk({tag, ".fwd_valid"},  32'(fwd_valid), 0);
    chk({tag, ".fwd_buf"},    32'(fwd_buf),   0);
    chk({tag, ".fwd_len"},    fwd_len,        0);
    chk({tag, ".acc_cnt"},    acc_cnt,        0);
    chk({tag, ".rej_cnt"},    rej_cnt,        0);
    chk({tag, ".wdog_trip"},  32'(wdog_trip), 0);
  endtask

  initial begin
    idle_inputs();
    last    = mk(0,0,0,0,0, 0,0, 1,0,0, 0, 0,0);
    prev_fv = 1'b0;

    // Fields: sd sl acc rej fd | grant gbuf cpu_rst cpu_buf plen fwd_valid acc rej
    tbl.push_back(mk(0, 0, 0,0,0, 1,0, 1,0, 0, 0, 0,0)); // buf0 granted
    tbl.push_back(mk(1,64, 0,0,0, 0,0, 1,0, 0, 0, 0,0)); // buf0 READY
    tbl.push_back(mk(0, 0, 0,0,0, 1,1, 0,0,64, 0, 0,0)); // CPU gets buf0, buf1 granted
    tbl.push_back(mk(0, 0, 1,0,0, 1,1, 1,0,64, 0, 1,0)); // accept
    tbl.push_back(mk(0, 0, 0,0,0, 1,1, 1,0,64, 1, 1,0)); // forwarder picks buf0
    tbl.push_back(mk(0, 0, 0,0,1, 1,1, 1,0,64, 0, 1,0)); // drained
    tbl.push_back(mk(1,70, 0,0,0, 0,1, 1,0,64, 0, 1,0)); // buf1 READY
    tbl.push_back(mk(0, 0, 0,0,0, 1,0, 0,1,70, 0, 1,0)); // CPU gets buf1, buf0 re-granted
    tbl.push_back(mk(1, 0, 0,0,0, 0,0, 0,1,70, 0, 1,1)); // zero length -> reject count
    tbl.push_back(mk(0, 0, 0,0,0, 1,0, 0,1,70, 0, 1,1)); // buf0 re-granted, no release
    tbl.push_back(mk(0, 0, 1,1,0, 1,0, 1,1,70, 0, 2,1)); // acc+rej: accept wins
    tbl.push_back(mk(1,60, 0,0,0, 0,0, 1,1,70, 1, 2,1)); // buf0 READY, fwd buf1
    tbl.push_back(mk(0, 0, 0,0,0, 0,0, 0,0,60, 1, 2,1)); // CPU gets buf0, nothing empty
    tbl.push_back(mk(0, 0, 0,1,0, 0,0, 1,0,60, 1, 2,2)); // reject buf0
    tbl.push_back(mk(0, 0, 0,0,1, 1,0, 1,0,60, 0, 2,2)); // drain buf1, buf0 granted
    tbl.push_back(mk(0, 0, 1,0,1, 1,0, 1,0,60, 0, 2,2)); // stray acc/fwd_done ignored

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

    // Reject the running packet while the next waits: one idle reset cycle, then buf1.
    apply(mk(1,60, 0,0,0, 0,0, 1,0,60, 0, 2,2), "seq3a"); // buf0 READY
    apply(mk(0, 0, 0,0,0, 1,1, 0,0,60, 0, 2,2), "seq3b"); // CPU buf0, buf1 granted
    apply(mk(1,70, 0,0,0, 0,1, 0,0,60, 0, 2,2), "seq3c"); // buf1 READY while CPU busy
    apply(mk(1,99, 0,0,0, 0,1, 0,0,60, 0, 2,2), "seq3d"); // sn_done with nothing filling
    apply(mk(0, 0, 0,1,0, 0,1, 1,0,60, 0, 2,3), "seq3e"); // reject -> cpu_rst high
    apply(mk(0, 0, 0,0,0, 1,0, 0,1,70, 0, 2,3), "seq3f"); // CPU buf1 after one cycle
    chk("sb_drained", 32'(sb.size()), 0);

    // Reset in the middle of FILTER: everything back to reset values.
    #3 rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst  = 1'b1;
    last = mk(0,0,0,0,0, 0,0, 1,0,0, 0, 0,0);
    prev_fv = 1'b0;
    apply(mk(0, 0, 0,0,0, 1,0, 1,0, 0, 0, 0,0), "post0");
    apply(mk(1,64, 0,0,0, 0,0, 1,0, 0, 0, 0,0), "post1");
    apply(mk(0, 0, 0,0,0, 1,1, 0,0,64, 0, 0,0), "post2");

`ifdef BPFVM_SCHED_WATCHDOG_EN
    // Released above: the 16th cycle in FILTER trips the watchdog.
    for (int k = 0; k < 14; k++) begin
      tick();
      chk($sformatf("wdog_quiet%0d", k), 32'(wdog_trip), 0);
    end
    chk("wdog_pre.cpu_rst", 32'(cpu_rst), 0);
    tick();
    chk("wdog_trip", 32'(wdog_trip), 1);
    chk("wdog_trip.cpu_rst", 32'(cpu_rst), 0);
    tick();
    chk("wdog_after.trip", 32'(wdog_trip), 0);
    chk("wdog_after.cpu_rst", 32'(cpu_rst), 1);
    chk("wdog_after.rej_cnt", rej_cnt, 1);
    chk("wdog_after.acc_cnt", acc_cnt, 0);
`else
    // Without the watchdog the CPU may take as long as it likes.
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("nowdog_trip%0d", k), 32'(wdog_trip), 0);
    end
    chk("nowdog.cpu_rst", 32'(cpu_rst), 0);
    chk("nowdog.rej_cnt", rej_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
